kbd_code_decoder: RTL

- Downstream of the PS/2 byte receiver. Consumes its parity-checked bytes (`din` + one-cycle `din_new` strobe).
- Assembles multi-byte scan-code sequences into single key events: press/release, standard/extended (E0).
- Tracks currently held keys in a small table.
- Feeds the game/display logic with clean `key_valid` pulses.

---
 rtl/kbd_pkg.sv | 34 +++
 rtl/kbd_held_table.sv | 79 +++++++
 rtl/kbd_code_decoder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// ============================================================================
// Module      : kbd_pkg
// Description : Shared constants, state encoding and types for the PS/2
//               scan-code decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kbd_pkg;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;
    localparam logic [7:0] SYS_ACK    = 8'hFA;
    localparam logic [7:0] SYS_BAT    = 8'hAA;
    localparam logic [7:0] SYS_ECHO   = 8'hEE;
    localparam logic [7:0] SYS_RESEND = 8'hFE;
    localparam logic [7:0] SYS_ERR0   = 8'h00;
    localparam logic [7:0] SYS_ERR1   = 8'hFF;

    typedef logic [8:0] key_code_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    function automatic logic is_sys_byte(input logic [7:0] b);
        return (b == SYS_ACK)    || (b == SYS_BAT)  || (b == SYS_ECHO) ||
               (b == SYS_RESEND) || (b == SYS_ERR0) || (b == SYS_ERR1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/kbd_held_table.sv
// ============================================================================
// Module      : kbd_held_table
// Description : Small table of currently held key codes with lookup,
//               lowest-free-slot insert, remove, population count and full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_held_table
    import kbd_pkg::*;
#(
    parameter int HELD_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ins_en,
    input  logic       rem_en,
    input  key_code_t  code,
    output logic       hit,
    output logic       full,
    output logic [3:0] held_cnt
);

    key_code_t             code_q [HELD_DEPTH];
    key_code_t             code_d [HELD_DEPTH];
    logic [HELD_DEPTH-1:0] valid_q;
    logic [HELD_DEPTH-1:0] valid_d;
    logic [HELD_DEPTH-1:0] w_match;
    logic                  w_placed;
    logic [3:0]            w_cnt;

    generate
        for (genvar i = 0; i < HELD_DEPTH; i++) begin : g_match
            assign w_match[i] = valid_q[i] && (code_q[i] == code);
        end
    endgenerate

    assign hit      = |w_match;
    assign full     = &valid_q;
    assign held_cnt = w_cnt;

    always_comb begin
        w_cnt = 4'd0;
        for (int i = 0; i < HELD_DEPTH; i++) begin
            w_cnt = w_cnt + 4'(valid_q[i]);
        end
    end

    always_comb begin
        valid_d  = valid_q;
        code_d   = code_q;
        w_placed = 1'b0;
        for (int i = 0; i < HELD_DEPTH; i++) begin
            if (ins_en && !w_placed && !valid_q[i]) begin
                valid_d[i] = 1'b1;
                code_d[i]  = code;
                w_placed   = 1'b1;
            end
            if (rem_en && w_match[i]) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < HELD_DEPTH; i++) begin
                code_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/kbd_code_decoder.sv
// ============================================================================
// Module      : kbd_code_decoder
// Description : Assembles PS/2 scan-code byte sequences into key press /
//               release events and tracks held keys. Defining
//               KBD_REPEAT_FILTER_EN suppresses typematic repeat presses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_code_decoder
    import kbd_pkg::*;
#(
    parameter int HELD_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_new,
    output logic [8:0] key_code,
    output logic       key_make,
    output logic       key_valid,
    output logic [7:0] sys_code,
    output logic       sys_valid,
    output logic [3:0] held_cnt,
    output logic       held_overflow
);

    localparam int                CNT_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    key_code_t        key_code_q, key_code_d;
    logic             key_make_q, key_make_d;
    logic             key_valid_q, key_valid_d;
    logic [7:0]       sys_code_q, sys_code_d;
    logic             sys_valid_q, sys_valid_d;
    logic             overflow_q, overflow_d;

    logic             w_ev_valid;
    key_code_t        w_ev_code;
    logic             w_ev_make;
    logic             w_hit;
    logic             w_full;
    logic             w_ins_en;
    logic             w_rem_en;
    logic             w_emit;

    // Sequence assembly; an arriving byte always wins over the timeout.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        w_ev_valid  = 1'b0;
        w_ev_code   = {1'b0, din};
        w_ev_make   = 1'b0;
        sys_valid_d = 1'b0;
        sys_code_d  = sys_code_q;
        if (din_new) begin
            cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (din == PREFIX_EXT) begin
                        state_d = ST_EXT;
                    end else if (din == PREFIX_BRK) begin
                        state_d = ST_BRK;
                    end else if (is_sys_byte(din)) begin
                        sys_valid_d = 1'b1;
                        sys_code_d  = din;
                    end else begin
                        w_ev_valid = 1'b1;
                        w_ev_make  = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (din == PREFIX_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (din != PREFIX_EXT) begin
                        w_ev_valid = 1'b1;
                        w_ev_code  = {1'b1, din};
                        w_ev_make  = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    state_d    = ST_IDLE;
                    w_ev_valid = (din != PREFIX_EXT) && (din != PREFIX_BRK);
                end
                default: begin
                    state_d    = ST_IDLE;
                    w_ev_valid = (din != PREFIX_EXT) && (din != PREFIX_BRK);
                    w_ev_code  = {1'b1, din};
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == c_timeout_last) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    kbd_held_table #(
        .HELD_DEPTH (HELD_DEPTH)
    ) u_held_table (
        .clk      (clk),
        .reset    (reset),
        .ins_en   (w_ins_en),
        .rem_en   (w_rem_en),
        .code     (w_ev_code),
        .hit      (w_hit),
        .full     (w_full),
        .held_cnt (held_cnt)
    );

    // A press of a key already held never changes the table or the overflow flag.
    always_comb begin
        w_ins_en   = w_ev_valid && w_ev_make && !w_hit && !w_full;
        w_rem_en   = w_ev_valid && !w_ev_make && w_hit;
        overflow_d = overflow_q || (w_ev_valid && w_ev_make && !w_hit && w_full);
`ifdef KBD_REPEAT_FILTER_EN
        w_emit     = w_ev_valid && !(w_ev_make && w_hit);
`else
        w_emit     = w_ev_valid;
`endif
        key_valid_d = w_emit;
        key_code_d  = w_emit ? w_ev_code : key_code_q;
        key_make_d  = w_emit ? w_ev_make : key_make_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_make_q  <= 1'b0;
            key_valid_q <= 1'b0;
            sys_code_q  <= '0;
            sys_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_make_q  <= key_make_d;
            key_valid_q <= key_valid_d;
            sys_code_q  <= sys_code_d;
            sys_valid_q <= sys_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign key_code      = key_code_q;
    assign key_make      = key_make_q;
    assign key_valid     = key_valid_q;
    assign sys_code      = sys_code_q;
    assign sys_valid     = sys_valid_q;
    assign held_overflow = overflow_q;

endmodule

`default_nettype wire
